// File: rtl/lc3b_dcache.sv
// lc3b_dcache: direct-mapped, write-back, write-allocate data cache for the LC-3b memory stage.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   mem_read/mem_write         CPU request, held until mem_resp (both high = write)
//   mem_byte_enable[1:0]       byte lanes for writes ([1] high, [0] low)
//   mem_address[15:0]          byte address (bit 0 ignored for word select)
//   mem_wdata[15:0]            write data
//   mem_rdata[15:0]            read data, valid with mem_resp on a read
//   mem_resp                   request complete this cycle
//   dcache_hit                 tag match on a valid line while a request is active
//   pmem_address[15:0]         line address for writeback/fill (low 4 bits zero)
//   pmem_rdata[127:0]          fill data
//   pmem_wdata[127:0]          victim line data
//   pmem_read/pmem_write       fill/writeback request, held until pmem_resp
//   pmem_resp                  physical transfer complete (one-cycle pulse)
//
// Optional feature (macro DCACHE_PERF_CNT_EN): adds saturating hit_count/miss_count outputs.
module lc3b_dcache #(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         dcache_hit,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    output logic [127:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int unsigned IDX = $clog2(NUM_SETS);
    localparam int unsigned TW  = 12 - IDX;

    typedef enum logic [1:0] {StCheck, StWriteback, StFill} state_e;

    state_e          state_q;
    logic            pmem_read_q, pmem_write_q;
    logic [TW-1:0]   miss_tag_q;
    logic [IDX-1:0]  miss_idx_q;
    logic [NUM_SETS-1:0] valid_q, dirty_q;
    logic [TW-1:0]   tag_q  [NUM_SETS];
    logic [15:0]     data_q [NUM_SETS][8];

    logic            req, line_match, hit, miss_evt;
    logic [TW-1:0]   req_tag;
    logic [IDX-1:0]  req_idx;
    logic [2:0]      req_word;
    logic            unused_addr0;

    assign unused_addr0 = mem_address[0];
    assign req        = mem_read | mem_write;
    assign req_tag    = mem_address[15:4+IDX];
    assign req_idx    = mem_address[3+IDX:4];
    assign req_word   = mem_address[3:1];
    assign line_match = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit        = (state_q == StCheck) && req && line_match;
    assign miss_evt   = (state_q == StCheck) && req && !line_match;

    // Miss line coordinates are captured on the miss so a dropped request still completes
    // its transfer to the right line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StCheck;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            miss_tag_q   <= '0;
            miss_idx_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            case (state_q)
                StCheck: begin
                    if (hit && mem_write) begin
                        dirty_q[req_idx] <= 1'b1;
                    end else if (miss_evt) begin
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            state_q      <= StWriteback;
                            pmem_write_q <= 1'b1;
                        end else begin
                            state_q     <= StFill;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                StWriteback: begin
                    if (pmem_resp) begin
                        dirty_q[miss_idx_q] <= 1'b0;
                        pmem_write_q        <= 1'b0;
                        pmem_read_q         <= 1'b1;
                        state_q             <= StFill;
                    end
                end
                StFill: begin
                    if (pmem_resp) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        pmem_read_q         <= 1'b0;
                        state_q             <= StCheck;
                    end
                end
                default: begin
                    state_q      <= StCheck;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Line data and tags are not reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (hit && mem_write) begin
            if (mem_byte_enable[0]) data_q[req_idx][req_word][7:0]  <= mem_wdata[7:0];
            if (mem_byte_enable[1]) data_q[req_idx][req_word][15:8] <= mem_wdata[15:8];
        end
        if (state_q == StFill && pmem_resp) begin
            for (int w = 0; w < 8; w++) begin
                data_q[miss_idx_q][w] <= pmem_rdata[16*w +: 16];
            end
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

    always_comb begin
        mem_resp     = hit;
        dcache_hit   = hit;
        mem_rdata    = '0;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_read    = pmem_read_q;
        pmem_write   = pmem_write_q;
        if (hit && !mem_write) begin
            mem_rdata = data_q[req_idx][req_word];
        end
        if (state_q == StWriteback) begin
            pmem_address = {tag_q[miss_idx_q], miss_idx_q, 4'b0000};
            for (int w = 0; w < 8; w++) begin
                pmem_wdata[16*w +: 16] = data_q[miss_idx_q][w];
            end
        end else if (state_q == StFill) begin
            pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        missed_q;  // current request already missed once

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            missed_q   <= 1'b0;
        end else begin
            if (hit && !missed_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (miss_evt && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            if (miss_evt) begin
                missed_q <= 1'b1;
            end else if (hit) begin
                missed_q <= 1'b0;
            end else if (state_q == StFill && pmem_resp && !req) begin
                missed_q <= 1'b0;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_lc3b_dcache.sv
// Self-checking bench for lc3b_dcache (NUM_SETS = 8): directed scenarios followed by random
// accesses, checked against a behavioural cache/memory model.
module tb_lc3b_dcache;

    localparam int unsigned NS = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = 2'b00;
    logic [15:0]  mem_address = '0, mem_wdata = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp, dcache_hit;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata = '0;
    logic [127:0] pmem_wdata;
    logic         pmem_read, pmem_write;
    logic         pmem_resp = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
    logic [15:0]  hit_count, miss_count;
`endif

    lc3b_dcache #(.NUM_SETS(NS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .dcache_hit      (dcache_hit),
        .pmem_address    (pmem_address),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_resp       (pmem_resp)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Physical memory and a behavioural picture of what each cache set holds.
    logic [127:0] phys [4096];
    logic         m_valid [NS];
    logic         m_dirty [NS];
    logic [8:0]   m_tag   [NS];
    logic [127:0] m_line  [NS];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Wait (bounded) for a pmem request, check it, then answer after lat extra cycles.
    // Called just after a rising edge; returns just after the edge that consumed pmem_resp.
    task automatic serve(input bit is_wr, input logic [15:0] addr, input logic [127:0] wdata,
                         input int lat);
        bit found;
        logic req_bit;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            req_bit = is_wr ? pmem_write : pmem_read;
            if (req_bit === 1'b1) found = 1'b1;
        end
        if (is_wr) check("pmem_write_seen", {127'd0, found}, 128'd1);
        else       check("pmem_read_seen", {127'd0, found}, 128'd1);
        if (!found) return;
        check("pmem_exclusive", {127'd0, pmem_read & pmem_write}, 128'd0);
        check("pmem_address", {112'd0, pmem_address}, {112'd0, addr});
        if (is_wr) check("pmem_wdata", pmem_wdata, wdata);
        for (int c = 0; c < lat; c++) begin
            @(posedge clk);
            @(negedge clk);
            req_bit = is_wr ? pmem_write : pmem_read;
            check("pmem_held", {127'd0, req_bit}, 128'd1);
        end
        if (!is_wr) pmem_rdata = phys[addr[15:4]];
        pmem_resp = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    // One CPU access, start to finish. Called just after a rising edge.
    task automatic access(input bit wr, input bit rd_too, input logic [15:0] addr,
                          input logic [1:0] be, input logic [15:0] wd, input int lat,
                          input bit drop);
        logic [2:0] idx;
        logic [8:0] tag;
        logic [2:0] w;
        bit         exp_hit;
        idx     = addr[6:4];
        tag     = addr[15:7];
        w       = addr[3:1];
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        mem_read        = wr ? rd_too : 1'b1;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_address     = addr;
        mem_wdata       = wd;
        @(negedge clk);
        check("first_hit", {127'd0, dcache_hit}, {127'd0, exp_hit});
        check("first_resp", {127'd0, mem_resp}, {127'd0, exp_hit});
        check("first_no_pmem", {127'd0, pmem_read | pmem_write}, 128'd0);
        if (!exp_hit) begin
            @(posedge clk);
            #1;
            if (drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            if (m_valid[idx] && m_dirty[idx]) begin
                serve(1'b1, {m_tag[idx], idx, 4'h0}, m_line[idx], lat);
                phys[{m_tag[idx], idx}] = m_line[idx];
                m_dirty[idx] = 1'b0;
            end
            serve(1'b0, {tag, idx, 4'h0}, '0, lat);
            m_line[idx]  = phys[{tag, idx}];
            m_tag[idx]   = tag;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            @(negedge clk);
            check("pmem_idle_after", {127'd0, pmem_read | pmem_write}, 128'd0);
            check("fill_resp", {127'd0, mem_resp}, {127'd0, !drop});
            check("fill_hit", {127'd0, dcache_hit}, {127'd0, !drop});
        end
        if (!drop) begin
            if (!wr) begin
                check("rdata", {112'd0, mem_rdata}, {112'd0, m_line[idx][16*w +: 16]});
            end else begin
                if (be[0]) m_line[idx][16*w +: 8]     = wd[7:0];
                if (be[1]) m_line[idx][16*w + 8 +: 8] = wd[15:8];
                m_dirty[idx] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        bit found_wb;
        logic [8:0] rtag;
        for (int i = 0; i < 4096; i++) phys[i] = {$urandom, $urandom, $urandom, $urandom};
        phys[12'h100][31:16] = 16'hBEEF;
        phys[12'h100][47:32] = 16'hAAAA;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_resp", {127'd0, mem_resp}, 128'd0);
        check("rst_hit", {127'd0, dcache_hit}, 128'd0);
        check("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
        check("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
        check("rst_pmem_address", {112'd0, pmem_address}, 128'd0);
        check("rst_pmem_wdata", pmem_wdata, 128'd0);
        check("rst_mem_rdata", {112'd0, mem_rdata}, 128'd0);
`ifdef DCACHE_PERF_CNT_EN
        check("rst_hit_count", {112'd0, hit_count}, 128'd0);
        check("rst_miss_count", {112'd0, miss_count}, 128'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Clean miss fill then hit; byte write; dirty conflict miss
        access(1'b0, 1'b0, 16'h1002, 2'b11, 16'h0000, 1, 1'b0);
        access(1'b0, 1'b0, 16'h1002, 2'b11, 16'h0000, 0, 1'b0);
        access(1'b1, 1'b0, 16'h1004, 2'b01, 16'h1234, 1, 1'b0);
        check("byte_merge_model", {112'd0, m_line[0][47:32]}, {112'd0, 16'hAA34});
        access(1'b0, 1'b0, 16'h1084, 2'b11, 16'h0000, 2, 1'b0);
`ifdef DCACHE_PERF_CNT_EN
        check("hit_count", {112'd0, hit_count}, 128'd2);
        check("miss_count", {112'd0, miss_count}, 128'd2);
`endif

        // Request dropped during fill, then a same-address hit
        access(1'b0, 1'b0, 16'h1130, 2'b11, 16'h0000, 2, 1'b1);
        access(1'b0, 1'b0, 16'h1130, 2'b11, 16'h0000, 0, 1'b0);

        // Reset during writeback
        access(1'b1, 1'b0, 16'h1130, 2'b11, 16'h5A5A, 0, 1'b0);
        mem_read    = 1'b1;
        mem_address = 16'h11B0;
        @(negedge clk);
        check("wb_rst_miss", {127'd0, dcache_hit}, 128'd0);
        @(posedge clk);
        #1;
        found_wb = 1'b0;
        for (int c = 0; c < 5 && !found_wb; c++) begin
            @(negedge clk);
            if (pmem_write === 1'b1) found_wb = 1'b1;
        end
        check("wb_rst_seen", {127'd0, found_wb}, 128'd1);
        check("wb_rst_addr", {112'd0, pmem_address}, {112'd0, 16'h1130});
        rst_n = 1'b0;
        #1;
        check("wb_rst_pmem_write", {127'd0, pmem_write}, 128'd0);
        check("wb_rst_pmem_read", {127'd0, pmem_read}, 128'd0);
        check("wb_rst_pmem_address", {112'd0, pmem_address}, 128'd0);
        check("wb_rst_resp", {127'd0, mem_resp}, 128'd0);
        mem_read = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        access(1'b0, 1'b0, 16'h1130, 2'b11, 16'h0000, 1, 1'b0);
        access(1'b0, 1'b0, 16'h1084, 2'b11, 16'h0000, 0, 1'b0);

        // Random accesses over a few conflicting tags
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 2))
                0:       rtag = 9'h020;
                1:       rtag = 9'h021;
                default: rtag = 9'h0A3;
            endcase
            access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   {rtag, 3'($urandom_range(0, 3)), 4'($urandom)},
                   2'($urandom), 16'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
